// File: rtl/decoder_2_to_4_buffered.sv
// decoder_2_to_4_buffered: a 2-to-4 one-hot decoder behind a two-entry
// valid/ready buffer (output register plus skid register), with saturating
// per-line hit counters.
// Latency: 1 cycle from input transfer to out_valid when the buffer is empty.
// Backpressure: in_ready is registered and drops only when both entries are
// full. There is no combinational path from out_ready to in_ready.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_code/in_en are sampled on transfer
//   in_code[1:0], in_en   line index and decode enable (en=0 -> all-zero word)
//   out_valid/out_ready   downstream handshake for out_lines[3:0]
//   clr_cnt               synchronous clear of all hit counters
//   hit_counts            counter k at [k*CNT_W +: CNT_W]
module decoder_2_to_4_buffered #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_code,
  input  logic               in_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_lines,
  input  logic               clr_cnt,
  output logic [4*CNT_W-1:0] hit_counts
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] out_word, out_word_nxt;
  logic [3:0] skid_word, skid_word_nxt;
  logic [3:0] dec_word;
  logic       ready_q;
  logic       accept;
  logic       drain;

  logic [CNT_W-1:0] cnt [4];

  assign dec_word  = in_en ? (4'b0001 << in_code) : 4'b0000;
  assign accept    = in_valid & ready_q;
  assign out_valid = (state != EMPTY);
  assign drain     = out_valid & out_ready;
  assign in_ready  = ready_q;
  // The output register may hold a stale word after draining; mask it so
  // the bus reads zero whenever nothing is offered.
  assign out_lines = out_valid ? out_word : 4'b0000;

  always_comb begin
    state_nxt     = state;
    out_word_nxt  = out_word;
    skid_word_nxt = skid_word;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          out_word_nxt = dec_word;
        end
      end
      ONE: begin
        if (accept && drain) begin
          // The departing word frees the output register, so the new word
          // goes straight there instead of through the skid register.
          out_word_nxt = dec_word;
        end else if (accept) begin
          state_nxt     = TWO;
          skid_word_nxt = dec_word;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        // ready_q is low here, so no accept can happen.
        if (drain) begin
          state_nxt    = ONE;
          out_word_nxt = skid_word;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      ready_q   <= 1'b0;
      out_word  <= 4'b0000;
      skid_word <= 4'b0000;
    end else begin
      state     <= state_nxt;
      // in_ready comes from next state, so it is exactly "not full" with
      // no dependence on this cycle's out_ready.
      ready_q   <= (state_nxt != TWO);
      out_word  <= out_word_nxt;
      skid_word <= skid_word_nxt;
    end
  end

  // Clear has priority over a simultaneous increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      for (int k = 0; k < 4; k++) begin
        cnt[k] <= '0;
      end
    end else if (drain) begin
      for (int k = 0; k < 4; k++) begin
        if (out_word[k] && (cnt[k] != {CNT_W{1'b1}})) begin
          cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_cnt_out
      assign hit_counts[g*CNT_W +: CNT_W] = cnt[g];
    end
  endgenerate

endmodule

// File: tb/tb_decoder_2_to_4_buffered.sv
// Directed testbench for decoder_2_to_4_buffered. Two instances share all
// inputs: dut uses the default 8-bit counters and dut2 uses 2-bit counters.
// Inputs change 1ns after the rising edge, and outputs are checked at the
// same point.
module tb_decoder_2_to_4_buffered;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_code;
  logic        in_en;
  logic        out_ready;
  logic        clr_cnt;

  logic        in_ready, out_valid;
  logic [3:0]  out_lines;
  logic [31:0] hit_counts;

  logic        in_ready2, out_valid2;
  logic [3:0]  out_lines2;
  logic [7:0]  hit_counts2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_2_to_4_buffered dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_en(in_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_lines(out_lines),
    .clr_cnt(clr_cnt), .hit_counts(hit_counts)
  );

  decoder_2_to_4_buffered #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_code(in_code), .in_en(in_en),
    .out_valid(out_valid2), .out_ready(out_ready), .out_lines(out_lines2),
    .clr_cnt(clr_cnt), .hit_counts(hit_counts2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt(input int k);
    return {24'd0, hit_counts[k*8 +: 8]};
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_code = 2'd0; in_en = 1'b1;
    out_ready = 1'b0; clr_cnt = 1'b0;

    // Reset state
    step(); step();
    check("rst_in_ready",  in_ready,   0);
    check("rst_out_valid", out_valid,  0);
    check("rst_out_lines", out_lines,  0);
    check("rst_counts",    hit_counts, 0);
    rst_n = 1'b1;
    step();
    check("rel_in_ready", in_ready, 1);

    // Single word, code 2
    in_valid = 1'b1; in_code = 2'd2; in_en = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("one_valid", out_valid, 1);
    check("one_lines", out_lines, 4'b0100);
    step();
    check("one_drained",   out_valid, 0);
    check("one_lines_off", out_lines, 0);
    check("one_cnt2",      cnt(2),    1);

    // Fill both entries under stall, then drain
    out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd1;
    step();
    check("fill1_ready", in_ready,  1);
    check("fill1_lines", out_lines, 4'b0010);
    in_code = 2'd3;
    step();
    in_valid = 1'b0;
    check("fill2_ready", in_ready,  0);
    check("fill2_valid", out_valid, 1);
    check("fill2_lines", out_lines, 4'b0010);
    step();
    check("stall_lines", out_lines, 4'b0010);
    check("stall_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    check("drain1_lines", out_lines, 4'b1000);
    check("drain1_ready", in_ready,  1);
    step();
    check("drain2_valid", out_valid, 0);
    check("drain_cnt1",   cnt(1),    1);
    check("drain_cnt3",   cnt(3),    1);

    // Clear counters, then stream 0..3 back to back
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_counts", hit_counts, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_w;
      exp_w = 4'b0001 << i;
      in_code = 2'(i);
      step();
      check($sformatf("stream_lines%0d", i), out_lines, exp_w);
      check($sformatf("stream_ready%0d", i), in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("stream_valid_end", out_valid, 0);
    check("stream_counts", hit_counts, {8'd1, 8'd1, 8'd1, 8'd1});

    // Disabled decode
    out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd3; in_en = 1'b0;
    step();
    in_valid = 1'b0; in_en = 1'b1;
    check("dis_valid", out_valid, 1);
    check("dis_lines", out_lines, 0);
    out_ready = 1'b1;
    step();
    check("dis_drained", out_valid,  0);
    check("dis_counts",  hit_counts, {8'd1, 8'd1, 8'd1, 8'd1});

    // Saturation with 2-bit counters, then clear colliding with an increment
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_code = 2'd0;
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    step();
    check("sat_cnt0_w2", hit_counts2[1:0], 3);
    check("sat_cnt0_w8", cnt(0), 5);
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clrwin_cnt0_w2", hit_counts2[1:0], 0);
    check("clrwin_cnt0_w8", cnt(0), 0);
    check("clrwin_valid",   out_valid2, 0);

    // Reset while full
    in_valid = 1'b1; in_code = 2'd3;
    step();
    in_valid = 1'b0;
    step();
    check("pre_cnt3", cnt(3), 1);
    out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd1;
    step();
    in_code = 2'd2;
    step();
    in_valid = 1'b0;
    check("full_ready", in_ready, 0);
    rst_n = 1'b0;
    step();
    check("midrst_valid",  out_valid,  0);
    check("midrst_ready",  in_ready,   0);
    check("midrst_lines",  out_lines,  0);
    check("midrst_counts", hit_counts, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    check("post_ready", in_ready,  1);
    check("post_valid", out_valid, 0);
    step();
    check("post_valid2", out_valid,  0);
    check("post_counts", hit_counts, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
